aes_decipher_ctrl: RTL and testbench
====================================

Name: aes_decipher_ctrl

Overview:
Sequential control and state-holding stage directly upstream of the combinational decipher round datapath.
- Accepts a 128-bit ciphertext block and latches it into the state register.
- Drives round_type and a descending round-key index to the round datapath and to the key memory.
- Captures the datapath's new state every cycle and presents the finished plaintext with a ready/valid indication.
- Supports AES-128 (10 rounds) and AES-256 (14 rounds).

Parameters:
INIT_ROUND, 0, round_type encoding for the initial AddRoundKey round
MAIN_ROUND, 1, round_type encoding for a full inverse round
FINAL_ROUND, 2, round_type encoding for the last round (no InvMixColumns)

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  asynchronous reset, active-high
next  in  1  start request; sampled only while ready=1
keylen  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled with next
block  in  128  ciphertext; sampled with next
state_new  in  128  new state returned by the round datapath (combinational from state_out)
round_type  out  2  round selector to the datapath
round  out  4  round-key index to the key memory
state_out  out  128  current state register, drives the round datapath
ready  out  1  1 = idle and able to accept next
result  out  128  equals state_out; meaningful only while result_valid=1
result_valid  out  1  1 = result holds the plaintext of the last accepted block

Behaviour:
- Reset values (asynchronous, active-high):
  - FSM = IDLE, state_reg = 0, round_ctr = 0, nr_reg = 0.
  - ready = 1, result_valid = 0, round_type = INIT_ROUND, round = 0.
- FSM states and transitions:
  - IDLE: round_type = INIT_ROUND, round = 0, state_reg held.
    - On next=1, at the edge: state_reg <= block; nr_reg <= 10 or 14 from keylen; round_ctr <= Nr; ready <= 0; result_valid <= 0; go to INIT.
  - INIT: round_type = INIT_ROUND, round = round_ctr (= Nr).
    - At the edge: state_reg <= state_new; round_ctr <= round_ctr - 1; go to MAIN.
  - MAIN: round_type = MAIN_ROUND, round = round_ctr.
    - At each edge: state_reg <= state_new; round_ctr <= round_ctr - 1.
    - If round_ctr == 1 at the edge, go to FINAL. The decrement makes round_ctr 0.
    - MAIN therefore lasts Nr-1 cycles, using keys Nr-1 down to 1.
  - FINAL: round_type = FINAL_ROUND, round = 0.
    - At the edge: state_reg <= state_new; ready <= 1; result_valid <= 1; go to IDLE.
- round and round_type are combinational decodes of the FSM state and round_ctr. round_ctr is 4 bits and never wraps: it is never decremented below 0.
- Latency: counting the acceptance edge as edge 1, ready and result_valid rise after edge Nr+2, i.e. 12 edges for AES-128 and 16 edges for AES-256.
  - The next accept is possible on the cycle ready is seen high.
- result_valid stays 1 until the next accepted start or a reset.
- next while ready=0 is ignored, with no queuing.
- block and keylen changes while busy are ignored; only the values latched at acceptance are used.
- next held high continuously starts back-to-back operations: each IDLE cycle with next=1 accepts immediately. That cycle shows ready=1 and result_valid=1 for the previous result.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is flagged valid.

Test Plan:
1. AES-128 vector: key 000102030405060708090a0b0c0d0e0f via bench key memory driven by round, real round datapath, block 69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0, next pulse → result 00112233445566778899aabbccddeeff with result_valid=1 exactly 12 edges after acceptance.
2. AES-256 vector: key 000102…1e1f, block 8ea2b7ca516745bfeafc49904b496089, keylen=1 → result 00112233445566778899aabbccddeeff after 16 edges.
3. Round trace with stub datapath (state_new = state_out ^ {124'b0, round}), block 0, keylen=0:
   - (round_type, round) sequence must be (0,10), (1,9) … (1,1), (2,0).
   - result = XOR of 10..0 = 0x0000…000b.
4. Busy protection: pulse next with a different block and keylen=1 at edges 3 and 7 of an AES-128 run → ignored; original result and 12-edge latency unchanged.
5. Reset mid-operation: assert reset during MAIN (round=5) → immediately ready=1, result_valid=0, state_out=0, round=0. A new start after release completes correctly (scenario 1 values).
6. Back-to-back: next held high across two AES-128 runs → second acceptance occurs on the single ready=1 cycle. First result is visible with result_valid=1 that cycle; result_valid drops the following cycle and the second result is valid 12 edges later.

Source files
------------

// File: rtl/aes_decipher_ctrl.sv
// Control and state register for an iterative AES decipher core (AES-128 / AES-256).
// Sequences round_type and a descending key index; the round datapath sits outside.
module aes_decipher_ctrl #(
    parameter logic [1:0] INIT_ROUND  = 2'd0,
    parameter logic [1:0] MAIN_ROUND  = 2'd1,
    parameter logic [1:0] FINAL_ROUND = 2'd2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    input  logic [127:0] state_new,
    output logic [1:0]   round_type,
    output logic [3:0]   round,
    output logic [127:0] state_out,
    output logic         ready,
    output logic [127:0] result,
    output logic         result_valid,
    output logic [1:0]   fsm_state
);

    // Handshake: a start is taken on any rising edge where ready=1 and next=1;
    // block/keylen are captured on that edge only. next while ready=0 is dropped.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_MAIN  = 2'd2,
        S_FINAL = 2'd3
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [127:0] state_reg;
    logic [3:0]   round_ctr;
    logic [3:0]   nr_reg;
    logic         ready_reg;
    logic         valid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (next) fsm_d = S_INIT;
            S_INIT:  fsm_d = S_MAIN;
            S_MAIN:  if (round_ctr <= 4'd1) fsm_d = S_FINAL;
            S_FINAL: fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        round_type = INIT_ROUND;
        round      = 4'd0;
        case (fsm_q)
            S_INIT: begin
                round_type = INIT_ROUND;
                round      = nr_reg;
            end
            S_MAIN: begin
                round_type = MAIN_ROUND;
                round      = round_ctr;
            end
            S_FINAL: begin
                round_type = FINAL_ROUND;
                round      = 4'd0;
            end
            default: begin
                round_type = INIT_ROUND;
                round      = 4'd0;
            end
        endcase
    end

    // The counter saturates at zero so a stray MAIN cycle can never wrap the key index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= 128'd0;
            round_ctr <= 4'd0;
            nr_reg    <= 4'd0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (next) begin
                        state_reg <= block;
                        nr_reg    <= keylen ? 4'd14 : 4'd10;
                        round_ctr <= keylen ? 4'd14 : 4'd10;
                        ready_reg <= 1'b0;
                        valid_reg <= 1'b0;
                    end
                end
                S_INIT, S_MAIN: begin
                    state_reg <= state_new;
                    if (round_ctr != 4'd0) begin
                        round_ctr <= round_ctr - 4'd1;
                    end
                end
                S_FINAL: begin
                    state_reg <= state_new;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign state_out    = state_reg;
    assign result       = state_reg;
    assign ready        = ready_reg;
    assign result_valid = valid_reg;
    assign fsm_state    = fsm_q;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl: a behavioural AES inverse round and key memory close the loop,
// plus a stub datapath that makes the round sequence visible in the result.
module tb_aes_decipher_ctrl;

    logic         clk;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic [127:0] state_new;
    logic [1:0]   round_type;
    logic [3:0]   round;
    logic [127:0] state_out;
    logic         ready;
    logic [127:0] result;
    logic         result_valid;
    logic [1:0]   fsm_state;

    int n_checks = 0;
    int n_err    = 0;

    logic         dp_stub   = 1'b0;
    logic         dp_key256 = 1'b0;
    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] rk128 [16];
    logic [127:0] rk256 [16];

    aes_decipher_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .next         (next),
        .keylen       (keylen),
        .block        (block),
        .state_new    (state_new),
        .round_type   (round_type),
        .round        (round),
        .state_out    (state_out),
        .ready        (ready),
        .result       (result),
        .result_valid (result_valid),
        .fsm_state    (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- AES reference helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h01;
        if (v == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic key_expand(input logic [255:0] key, input int nk, input bit is256);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (is256) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else       rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // One inverse round: 0 = AddRoundKey only, 1 = full, 2 = without InvMixColumns.
    function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic [1:0] rt);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] o;
        if (rt == 2'd0) return st ^ key;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = isbox_t[a[4*((c-r+4)%4)+r]] ^ key[127-8*(4*c+r) -: 8];
        if (rt == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = b[4*c+r];
                b[4*c]   = gmul(a[0], 8'd14) ^ gmul(a[1], 8'd11) ^ gmul(a[2], 8'd13) ^ gmul(a[3], 8'd9);
                b[4*c+1] = gmul(a[0], 8'd9)  ^ gmul(a[1], 8'd14) ^ gmul(a[2], 8'd11) ^ gmul(a[3], 8'd13);
                b[4*c+2] = gmul(a[0], 8'd13) ^ gmul(a[1], 8'd9)  ^ gmul(a[2], 8'd14) ^ gmul(a[3], 8'd11);
                b[4*c+3] = gmul(a[0], 8'd11) ^ gmul(a[1], 8'd13) ^ gmul(a[2], 8'd9)  ^ gmul(a[3], 8'd14);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    always_comb begin
        if (dp_stub) state_new = state_out ^ {124'b0, round};
        else         state_new = inv_round(state_out, dp_key256 ? rk256[round] : rk128[round], round_type);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and counts edges from acceptance (edge 1) until ready returns.
    task automatic run_op(input logic kl, input logic [127:0] blk, input logic [127:0] exp,
                          input int exp_lat, input bit inject, input string nm);
        int lat;
        check({nm, "_ready_before"}, {127'b0, ready}, 128'd1);
        dp_key256 = kl;
        next = 1'b1; keylen = kl; block = blk;
        tick();
        next = 1'b0;
        check({nm, "_busy_ready"}, {127'b0, ready}, 128'd0);
        check({nm, "_busy_valid"}, {127'b0, result_valid}, 128'd0);
        lat = 1;
        while (!ready && lat < 40) begin
            if (inject && (lat == 2 || lat == 6)) begin
                next = 1'b1; keylen = ~kl; block = ~blk;
            end else begin
                next = 1'b0; keylen = kl; block = blk;
            end
            tick();
            lat++;
        end
        next = 1'b0;
        check({nm, "_latency"}, 128'(lat), 128'(exp_lat));
        check({nm, "_result"}, result, exp);
        check({nm, "_valid"}, {127'b0, result_valid}, 128'd1);
    endtask

    typedef struct packed {
        logic         kl;
        logic [127:0] blk;
        logic [127:0] exp;
        logic [4:0]   lat;
    } vec_t;

    typedef struct packed {
        logic [1:0] rt;
        logic [3:0] rnd;
        logic       rdy;
    } trace_t;

    localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;

    vec_t   vecs  [2];
    trace_t trace [12];

    initial begin
        int  cyc;
        bit  found;

        vecs[0] = '{kl: 1'b0, blk: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, exp: PLAIN, lat: 5'd12};
        vecs[1] = '{kl: 1'b1, blk: 128'h8ea2b7ca516745bfeafc49904b496089, exp: PLAIN, lat: 5'd16};
        trace[0] = '{rt: 2'd0, rnd: 4'd10, rdy: 1'b0};
        for (int i = 1; i <= 9; i++) trace[i] = '{rt: 2'd1, rnd: 4'(10 - i), rdy: 1'b0};
        trace[10] = '{rt: 2'd2, rnd: 4'd0, rdy: 1'b0};
        trace[11] = '{rt: 2'd0, rnd: 4'd0, rdy: 1'b1};

        reset = 1'b1; next = 1'b0; keylen = 1'b0; block = 128'd0;

        for (int v = 0; v < 256; v++) begin
            sbox_t[v]              = sbox_calc(8'(v));
            isbox_t[sbox_t[v]]     = 8'(v);
        end
        for (int r = 0; r < 16; r++) begin
            rk128[r] = 128'd0;
            rk256[r] = 128'd0;
        end
        key_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 1'b0);
        key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1'b1);

        #1;
        check("rst_ready", {127'b0, ready}, 128'd1);
        check("rst_valid", {127'b0, result_valid}, 128'd0);
        check("rst_round_type", {126'b0, round_type}, 128'd0);
        check("rst_round", {124'b0, round}, 128'd0);
        check("rst_state", state_out, 128'd0);
        check("rst_fsm", {126'b0, fsm_state}, 128'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Known-answer vectors
        for (int i = 0; i < 2; i++)
            run_op(vecs[i].kl, vecs[i].blk, vecs[i].exp, int'(vecs[i].lat), 1'b0,
                   (i == 0) ? "aes128" : "aes256");

        // Round sequence trace with the stub datapath
        dp_stub = 1'b1;
        next = 1'b1; keylen = 1'b0; block = 128'd0;
        tick();
        next = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("trace%0d_type", i), {126'b0, round_type}, {126'b0, trace[i].rt});
            check($sformatf("trace%0d_round", i), {124'b0, round}, {124'b0, trace[i].rnd});
            check($sformatf("trace%0d_ready", i), {127'b0, ready}, {127'b0, trace[i].rdy});
            if (i < 11) tick();
        end
        check("trace_result", result, 128'h0b);
        check("trace_valid", {127'b0, result_valid}, 128'd1);
        dp_stub = 1'b0;

        // Starts while busy must be ignored
        run_op(1'b0, vecs[0].blk, PLAIN, 12, 1'b1, "busy");

        // Reset in the middle of MAIN
        dp_key256 = 1'b0;
        next = 1'b1; keylen = 1'b0; block = vecs[0].blk;
        tick();
        next = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 20) begin
            if (round_type == 2'd1 && round == 4'd5) found = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check("midrst_reach_round5", {127'b0, found}, 128'd1);
        reset = 1'b1;
        #1;
        check("midrst_ready", {127'b0, ready}, 128'd1);
        check("midrst_valid", {127'b0, result_valid}, 128'd0);
        check("midrst_state", state_out, 128'd0);
        check("midrst_round", {124'b0, round}, 128'd0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_valid_after", {127'b0, result_valid}, 128'd0);
        run_op(1'b0, vecs[0].blk, PLAIN, 12, 1'b0, "after_rst");

        // Back-to-back with next held high
        dp_key256 = 1'b0;
        next = 1'b1; keylen = 1'b0; block = vecs[0].blk;
        tick();
        cyc = 1;
        while (!ready && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b_first_latency", 128'(cyc), 128'd12);
        check("b2b_first_result", result, PLAIN);
        check("b2b_first_valid", {127'b0, result_valid}, 128'd1);
        tick();
        next = 1'b0;
        check("b2b_second_ready", {127'b0, ready}, 128'd0);
        check("b2b_second_valid_drop", {127'b0, result_valid}, 128'd0);
        cyc = 1;
        while (!ready && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b_second_latency", 128'(cyc), 128'd12);
        check("b2b_second_result", result, PLAIN);
        check("b2b_second_valid", {127'b0, result_valid}, 128'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
